// File: rtl/ws_sta_output_collector.sv
// Output drain for the weight-stationary systolic array: deskews the diagonally
// skewed result lanes into full rows, buffers them with a row tag and returns credit.
module ws_sta_output_collector #(
  parameter int N     = 32,
  parameter int W     = 21,
  parameter int DEPTH = 8,
  parameter int TAGW  = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N*W-1:0]      io_inC,
  input  logic                io_inValid,
  output logic                io_inReady,
  input  logic                io_clear,
  output logic [N*W-1:0]      io_outData,
  output logic [TAGW-1:0]     io_outTag,
  output logic                io_outValid,
  input  logic                io_outReady,
  output logic                io_overflow,
  output logic [15:0]         io_dropCount
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(N);
  localparam int OW = ((CW > IW) ? CW : IW) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [OW-1:0] DEPTH_O = OW'(DEPTH);

  // Deskew: lane j waits N-1-j cycles so every lane lines up with the last one.
  logic [N*W-1:0] aligned;

  for (genvar j = 0; j < N - 1; j++) begin : g_lane
    localparam int L = N - 1 - j;
    logic [W-1:0] pipe_q [L];
    logic [W-1:0] pipe_d [L];

    always_comb begin
      pipe_d[0] = io_inC[j*W +: W];
      for (int s = 1; s < L; s++) pipe_d[s] = pipe_q[s-1];
    end

    always_ff @(posedge clock) begin
      pipe_q <= pipe_d;
    end

    assign aligned[j*W +: W] = pipe_q[L-1];
  end
  assign aligned[(N-1)*W +: W] = io_inC[(N-1)*W +: W];

  logic [N-2:0]      vld_q, vld_d;
  logic [IW-1:0]     inflight_q, inflight_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [TAGW-1:0]   tag_q, tag_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic              row_done, pop, wr_en, drop;
  logic [OW-1:0]     occupancy;

  logic [TAGW+N*W-1:0] mem_q [DEPTH];

  assign row_done = vld_q[N-2];

  always_comb begin
    vld_d      = vld_q;
    inflight_d = inflight_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    tag_d      = tag_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    pop        = 1'b0;
    wr_en      = 1'b0;
    drop       = 1'b0;

    if (io_clear) begin
      vld_d      = '0;
      inflight_d = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      tag_d      = '0;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else begin
      pop   = io_outValid && io_outReady;
      // A full FIFO still takes the row when the head leaves on the same edge.
      wr_en = row_done && ((count_q < DEPTH_C) || pop);
      drop  = row_done && !wr_en;

      vld_d = (vld_q << 1) | (N-1)'(io_inValid);

      unique case ({io_inValid, row_done})
        2'b10:   inflight_d = inflight_q + 1'b1;
        2'b01:   inflight_d = inflight_q - 1'b1;
        default: inflight_d = inflight_q;
      endcase

      unique case ({wr_en, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase

      if (wr_en)    wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)      rd_ptr_d = rd_ptr_q + 1'b1;
      if (row_done) tag_d    = tag_q + 1'b1;
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_q      <= '0;
      inflight_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tag_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      vld_q      <= vld_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tag_q      <= tag_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= {tag_q, aligned};
  end

  // Head is masked while empty so the unreset storage never shows on the outputs.
  assign io_outValid = (count_q != '0);
  assign {io_outTag, io_outData} = io_outValid ? mem_q[rd_ptr_q] : '0;

  assign occupancy    = OW'(count_q) + OW'(inflight_q);
  assign io_inReady   = (occupancy < DEPTH_O);
  assign io_overflow  = overflow_q;
  assign io_dropCount = drop_cnt_q;

endmodule

// File: tb/tb_ws_sta_output_collector.sv
// Directed bench for ws_sta_output_collector: deskew latency, tags, credit,
// overflow, full+pop, clear and asynchronous reset.
module tb_ws_sta_output_collector;

  localparam int N     = 32;
  localparam int W     = 21;
  localparam int DEPTH = 8;
  localparam int TAGW  = 8;
  localparam int VW    = N * W;

  logic            clock;
  logic            reset;
  logic [VW-1:0]   io_inC;
  logic            io_inValid;
  logic            io_inReady;
  logic            io_clear;
  logic [VW-1:0]   io_outData;
  logic [TAGW-1:0] io_outTag;
  logic            io_outValid;
  logic            io_outReady;
  logic            io_overflow;
  logic [15:0]     io_dropCount;

  ws_sta_output_collector #(.N(N), .W(W), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_inC       (io_inC),
    .io_inValid   (io_inValid),
    .io_inReady   (io_inReady),
    .io_clear     (io_clear),
    .io_outData   (io_outData),
    .io_outTag    (io_outTag),
    .io_outValid  (io_outValid),
    .io_outReady  (io_outReady),
    .io_overflow  (io_overflow),
    .io_dropCount (io_dropCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit hv [4096];
  int hb [4096];
  bit hu [4096];

  function automatic logic [VW-1:0] mk(input int base, input bit up);
    logic [VW-1:0] r;
    for (int j = 0; j < N; j++) r[j*W +: W] = W'(up ? base + j : base - j);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle; lane j carries the row launched j cycles earlier.
  task automatic step(input bit v, input int base, input bit up);
    hv[cyc] = v; hb[cyc] = base; hu[cyc] = up;
    for (int j = 0; j < N; j++) begin
      int c;
      c = cyc - j;
      if (c >= 0 && hv[c]) io_inC[j*W +: W] = W'(hu[c] ? hb[c] + j : hb[c] - j);
      else                 io_inC[j*W +: W] = '0;
    end
    io_inValid = v;
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);
    reset = 1'b0;
  endtask

  initial begin
    int n;
    int hits;
    reset = 1'b1; io_inC = '0; io_inValid = 0; io_clear = 0; io_outReady = 0;
    for (int i = 0; i < 4096; i++) begin hv[i] = 0; hb[i] = 0; hu[i] = 0; end
    step(0, 0, 0);
    chk("rst_valid", io_outValid, 0);
    chk("rst_data", io_outData, 0);
    chk("rst_tag", io_outTag, 0);
    chk("rst_inready", io_inReady, 1);
    chk("rst_overflow", io_overflow, 0);
    chk("rst_dropcount", io_dropCount, 0);
    step(0, 0, 0);
    reset = 1'b0;

    // Single row: lane j = j+1, visible 32 cycles after launch.
    step(1, 1, 1);
    for (int k = 0; k < 30; k++) step(0, 0, 0);
    chk("single_not_early", io_outValid, 0);
    step(0, 0, 0);
    chk("single_valid", io_outValid, 1);
    chk("single_data", io_outData, mk(1, 1));
    chk("single_tag", io_outTag, 0);
    io_outReady = 1;
    step(0, 0, 0);
    chk("single_popped", io_outValid, 0);
    chk("single_empty_data", io_outData, 0);

    // Back-to-back: row r lane j = 255-r-j, rows out in cycles 32..39.
    do_reset();
    io_outReady = 1;
    for (int k = 0; k < 40; k++) begin
      if (k < 8) chk("b2b_inready", io_inReady, 1);
      step(k < 8, 255 - k, 0);
      if (k + 1 >= 32 && k + 1 <= 39) begin
        chk("b2b_valid", io_outValid, 1);
        chk("b2b_tag", io_outTag, k + 1 - 32);
        chk("b2b_data", io_outData, mk(255 - (k + 1 - 32), 0));
      end else if (k + 1 == 31) begin
        chk("b2b_not_early", io_outValid, 0);
      end
    end
    chk("b2b_drained", io_outValid, 0);

    // Credit: only 8 launches fit while nothing drains.
    do_reset();
    io_outReady = 0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (k == 8) chk("credit_blocked", io_inReady, 0);
      if (io_inReady) begin
        step(1, 100 + n, 1);
        n++;
      end else begin
        step(0, 0, 0);
      end
    end
    chk("credit_launches", n, 8);
    chk("credit_no_overflow", io_overflow, 0);
    chk("credit_full_ready", io_inReady, 0);
    chk("credit_head_tag", io_outTag, 0);
    chk("credit_head_data", io_outData, mk(100, 1));
    io_outReady = 1;
    step(0, 0, 0);
    chk("credit_ready_back", io_inReady, 1);
    for (int r = 1; r < 8; r++) begin
      chk("credit_drain_tag", io_outTag, r);
      chk("credit_drain_data", io_outData, mk(100 + r, 1));
      step(0, 0, 0);
    end
    chk("credit_drained", io_outValid, 0);

    // Violation: two launches beyond credit, both dropped at rowDone.
    do_reset();
    io_outReady = 0;
    for (int k = 0; k < 46; k++) begin
      if (k == 8) chk("viol_blocked", io_inReady, 0);
      step(k < 10, 50 + k, 1);
      if (k + 1 == 39) chk("viol_ovf_before", io_overflow, 0);
      if (k + 1 == 40) chk("viol_drop_one", io_dropCount, 1);
    end
    chk("viol_overflow", io_overflow, 1);
    chk("viol_dropcount", io_dropCount, 2);
    io_outReady = 1;
    for (int r = 0; r < 7; r++) begin
      chk("viol_tag", io_outTag, r);
      chk("viol_data", io_outData, mk(50 + r, 1));
      step(0, 0, 0);
    end
    io_outReady = 0;
    chk("viol_last_tag", io_outTag, 7);
    chk("viol_last_data", io_outData, mk(57, 1));

    // Asynchronous reset in the middle of a cycle.
    #2;
    reset = 1'b1;
    #1;
    chk("areset_valid", io_outValid, 0);
    chk("areset_data", io_outData, 0);
    chk("areset_tag", io_outTag, 0);
    chk("areset_inready", io_inReady, 1);
    chk("areset_overflow", io_overflow, 0);
    chk("areset_dropcount", io_dropCount, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    reset = 1'b0;

    // Full FIFO, extra row arrives while the head is popped on the same edge.
    io_outReady = 0;
    for (int k = 0; k < 45; k++) begin
      io_outReady = (k == 39);
      step(k < 9, (k == 8) ? 200 : 10 + k, k != 8);
    end
    io_outReady = 0;
    chk("fullpop_no_overflow", io_overflow, 0);
    chk("fullpop_no_drop", io_dropCount, 0);
    chk("fullpop_valid", io_outValid, 1);
    io_outReady = 1;
    for (int i = 0; i < 8; i++) begin
      chk("fullpop_tag", io_outTag, i + 1);
      chk("fullpop_data", io_outData, (i < 7) ? mk(11 + i, 1) : mk(200, 0));
      step(0, 0, 0);
    end
    chk("fullpop_drained", io_outValid, 0);

    // Clear with 2 rows buffered and 3 in flight.
    do_reset();
    io_outReady = 0;
    for (int k = 0; k < 34; k++) begin
      if (k == 33) begin
        chk("clr_pre_valid", io_outValid, 1);
        chk("clr_pre_tag", io_outTag, 0);
        io_clear = 1;
      end
      step(k == 0 || k == 1 || (k >= 20 && k <= 22) || k == 33, 30 + k, 1);
    end
    io_clear = 0;
    chk("clr_valid", io_outValid, 0);
    chk("clr_inready", io_inReady, 1);
    chk("clr_data", io_outData, 0);
    hits = 0;
    for (int k = 0; k < 40; k++) begin
      step(0, 0, 0);
      if (io_outValid) hits++;
    end
    chk("clr_no_ghost_rows", hits, 0);
    step(1, 77, 1);
    for (int k = 0; k < 31; k++) step(0, 0, 0);
    chk("clr_new_valid", io_outValid, 1);
    chk("clr_new_tag", io_outTag, 0);
    chk("clr_new_data", io_outData, mk(77, 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ws_sta_output_collector.md
# ws_sta_output_collector

Output-side drain for the weight-stationary systolic array (`dimension_aligned_ws_sta_*`). The array emits each result row diagonally skewed: column j of a row appears j cycles after column 0. This block re-aligns the columns into one full row word. It buffers rows in a FIFO and hands them downstream over a valid/ready handshake, each tagged with a row index. It also returns credit-based flow control (`io_inReady`) to the operand sequencer.

## Interface
- `N`, 32: array columns (number of `outputC` lanes); N ≥ 2.
- `W`, 21: width of one `outputC` lane.
- `DEPTH`, 8: row FIFO depth in rows; power of two, ≥ 2.
- `TAGW`, 8: row-tag width.
- `clock`, in, 1: single clock; all state on rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `io_inC`, in, N*W: packed array outputs; lane j = bits [j*W +: W] = `io_outputC_j`.
- `io_inValid`, in, 1: column 0 of a valid row is on lane 0 this cycle.
- `io_inReady`, out, 1: sequencer may launch a new row (credit available).
- `io_clear`, in, 1: synchronous flush.
- `io_outData`, out, N*W: aligned row; lane j = column j.
- `io_outTag`, out, TAGW: row index of `io_outData`.
- `io_outValid`, out, 1: FIFO head valid.
- `io_outReady`, in, 1: downstream accepts head.
- `io_overflow`, out, 1: sticky; a completed row was dropped.
- `io_dropCount`, out, 16: number of dropped rows; saturates at 0xFFFF.

## Operation
- Deskew: lane j is passed through (N-1-j) register stages; lane N-1 is combinational. `io_inValid` is delayed N-1 stages to form `rowDone`. In the cycle `rowDone`=1, all N delayed lanes hold the same row.
- Tag: a TAGW counter increments on each `rowDone`. It wraps modulo 2^TAGW and is stored in the FIFO with the row. The first row after reset or clear gets tag 0.
- FIFO write on `rowDone` if `count < DEPTH`, or if `count == DEPTH` and a pop occurs in the same cycle.
- Otherwise the row is dropped: `io_overflow` is set and `io_dropCount` increments. The tag counter still advances.
- Pop when `io_outValid && io_outReady`. The head is presented registered from the FIFO; `io_outData`/`io_outTag` stay stable while `io_outValid && !io_outReady`.
- Credit: `inflight` counts rows between `io_inValid` and `rowDone`, range 0..N-1.
  - Occupancy = `count + inflight`.
  - `io_inReady = (occupancy < DEPTH)`, combinational from registers.
  - Simultaneous increment and decrement of `inflight` leaves it unchanged.
- `io_inValid` while `io_inReady`=0 is accepted into the deskew anyway. It is a protocol violation; the resulting row is dropped only if the FIFO is still full at `rowDone`.
- `io_clear` (synchronous, priority over all else):
  - zeroes the deskew valid pipe, `inflight`, FIFO pointers/count, tag, `io_overflow` and `io_dropCount`;
  - deskew data registers are untouched;
  - an `io_inValid` in the clear cycle is discarded.
- Reset values: `io_outValid` 0, `io_outData` 0, `io_outTag` 0, `io_inReady` 1, `io_overflow` 0, `io_dropCount` 0, and all internal valids/pointers/counters 0. Reset mid-row discards all in-flight rows.
- No arithmetic on data; lanes are carried bit-exact.

## Timing
- `io_inValid` in cycle t: lane j is sampled in cycle t+j, `rowDone` fires in cycle t+N-1, and the FIFO is written at the end of t+N-1.
- `io_outValid` rises in cycle t+N if the FIFO was empty. Latency is N cycles (32 at default).
- Throughput is one row per cycle, sustained while `io_outReady`=1 and credits are available.
- Pop takes effect at the clock edge. The next head is visible the following cycle with no bubble when `count ≥ 2`.
- `io_inReady` reflects state as of the previous edge. A launch in cycle t reduces credit from t+1.
- Full + `rowDone` + pop in the same cycle: the write is accepted and `count` stays at DEPTH.

## Test plan
- **Single row.** Reset; one `io_inValid` at cycle 0, with lane j = j+1 in cycle j and 0 otherwise.
  - Required: `io_outValid` at cycle 32, `io_outData` lane j = j+1, tag 0.
- **Back-to-back.** 8 consecutive rows; row r lane j = 255-r-j in cycle r+j; `io_outReady`=1.
  - Required: rows out in cycles 32..39, tags 0..7, all data exact, `io_inReady` never 0.
- **Credit.** `io_outReady`=0; launch rows every cycle while `io_inReady`.
  - Required: exactly 8 launches accepted, `io_inReady`=0 from the cycle after the 8th launch, no overflow.
  - Then `io_outReady`=1: 8 rows drain; `io_inReady` returns 1 the cycle after the first pop.
- **Violation.** Same as credit, but force 2 extra launches while `io_inReady`=0 and hold `io_outReady`=0.
  - Required: `io_overflow`=1, `io_dropCount`=2, surviving tags 0..7.
- **Full + simultaneous pop.** Hold the FIFO full; assert `io_outReady` in the `rowDone` cycle.
  - Required: no drop; the new row appears after the 8 older ones.
- **Clear / reset mid-operation.** Assert `io_clear` with 3 rows in flight and 2 buffered.
  - Required: next cycle `io_outValid`=0, `io_inReady`=1, and the next row gets tag 0.
  - Repeat with async `reset` mid-cycle: outputs go to reset values immediately.
